// File: rtl/ingress_1r2wg_pkg.sv
// Shared types for the 1R2W-generic request ingress stage: FSM states and
// the request records held in the ingress FIFOs.
package ingress_1r2wg_pkg;

   localparam int unsigned DEF_WIDTH   = 32;
   localparam int unsigned DEF_BITADDR = 13;
   localparam int unsigned DEF_BITTAG  = 4;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      HOLD
   } state_t;

   typedef struct packed {
      logic [DEF_BITADDR-1:0] adr;
      logic [DEF_BITTAG-1:0]  tag;
   } rd_req_t;

   typedef struct packed {
      logic [DEF_BITADDR-1:0] adr;
      logic [DEF_WIDTH-1:0]   din;
   } wr_req_t;

endpackage

// File: rtl/fifo_1r2wg_req.sv
// Show-ahead synchronous FIFO; wrap-bit pointers distinguish full from empty.
module fifo_1r2wg_req #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned BITDEP = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [BITDEP:0]  wptr;
   logic [BITDEP:0]  rptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr[BITDEP-1:0]] <= din;
   end

   assign dout  = mem[rptr[BITDEP-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[BITDEP] != rptr[BITDEP]) &&
                  (wptr[BITDEP-1:0] == rptr[BITDEP-1:0]);

endmodule

// File: rtl/ingress_1r2wg_req_q.sv
// Request ingress for the 1R2W-generic core: queues reads/writes, issues them
// while the core is ready, and pairs returning read data with issued tags.
module ingress_1r2wg_req_q
   import ingress_1r2wg_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned BITADDR = DEF_BITADDR,
   parameter int unsigned NUMWRPT = 2,
   parameter int unsigned FIFODEP = 4,
   parameter int unsigned BITFIFO = 2,
   parameter int unsigned BITTAG  = DEF_BITTAG,
   parameter int unsigned TAGDEP  = 8,
   parameter int unsigned BITTAGD = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rq_vld,
   output logic                       rq_rdy,
   input  logic [BITADDR-1:0]         rq_adr,
   input  logic [BITTAG-1:0]          rq_tag,
   input  logic [NUMWRPT-1:0]         wq_vld,
   output logic [NUMWRPT-1:0]         wq_rdy,
   input  logic [NUMWRPT*BITADDR-1:0] wq_adr,
   input  logic [NUMWRPT*WIDTH-1:0]   wq_din,
   output logic                       read,
   output logic [BITADDR-1:0]         rd_adr,
   output logic [NUMWRPT-1:0]         write,
   output logic [NUMWRPT*BITADDR-1:0] wr_adr,
   output logic [NUMWRPT*WIDTH-1:0]   din,
   input  logic                       ready,
   input  logic                       rd_vld,
   input  logic [WIDTH-1:0]           rd_dout,
   input  logic                       rd_serr,
   input  logic                       rd_derr,
   output logic                       rs_vld,
   output logic [BITTAG-1:0]          rs_tag,
   output logic [WIDTH-1:0]           rs_dout,
   output logic [1:0]                 rs_err,
   output logic                       err_unexp
);

   state_t              state;
   state_t              state_nxt;
   logic                live;
   logic                run;

   rd_req_t             rq_in;
   rd_req_t             rq_head;
   logic                rq_full;
   logic                rq_empty;
   logic                rq_push;
   logic                rd_go;

   wr_req_t             wq_in   [NUMWRPT];
   wr_req_t             wq_head [NUMWRPT];
   logic [NUMWRPT-1:0]  wq_full;
   logic [NUMWRPT-1:0]  wq_empty;
   logic [NUMWRPT-1:0]  wq_push;
   logic [NUMWRPT-1:0]  wr_go;

   logic [BITTAG-1:0]   tag_head;
   logic                tag_full;
   logic                tag_empty;
   logic                tag_pop;

   // Holds rdy low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) live <= 1'b0;
      else      live <= 1'b1;
   end

   assign rq_rdy  = live & ~rq_full;
   assign rq_push = rq_vld & rq_rdy;
   assign rq_in   = '{adr: rq_adr, tag: rq_tag};

   fifo_1r2wg_req #(
      .WIDTH ($bits(rd_req_t)),
      .DEPTH (FIFODEP),
      .BITDEP(BITFIFO)
   ) u_rd_q (
      .clk  (clk),
      .rst  (rst),
      .push (rq_push),
      .din  (rq_in),
      .pop  (rd_go),
      .dout (rq_head),
      .full (rq_full),
      .empty(rq_empty)
   );

   for (genvar g = 0; g < NUMWRPT; g++) begin : g_wq
      assign wq_in[g]   = '{adr: wq_adr[g*BITADDR +: BITADDR], din: wq_din[g*WIDTH +: WIDTH]};
      assign wq_rdy[g]  = live & ~wq_full[g];
      assign wq_push[g] = wq_vld[g] & wq_rdy[g];

      fifo_1r2wg_req #(
         .WIDTH ($bits(wr_req_t)),
         .DEPTH (FIFODEP),
         .BITDEP(BITFIFO)
      ) u_wr_q (
         .clk  (clk),
         .rst  (rst),
         .push (wq_push[g]),
         .din  (wq_in[g]),
         .pop  (wr_go[g]),
         .dout (wq_head[g]),
         .full (wq_full[g]),
         .empty(wq_empty[g])
      );
   end

   fifo_1r2wg_req #(
      .WIDTH (BITTAG),
      .DEPTH (TAGDEP),
      .BITDEP(BITTAGD)
   ) u_tag_q (
      .clk  (clk),
      .rst  (rst),
      .push (rd_go),
      .din  (rq_head.tag),
      .pop  (tag_pop),
      .dout (tag_head),
      .full (tag_full),
      .empty(tag_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= INIT;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (ready)  state_nxt = RUN;
         RUN:     if (!ready) state_nxt = HOLD;
         HOLD:    if (ready)  state_nxt = RUN;
         default: state_nxt = INIT;
      endcase
   end

   // Port 1 defers to port 0 on an address clash so its value lands last.
   always_comb begin
      run      = (state == RUN) && ready;
      rd_go    = run && !rq_empty && !tag_full;
      wr_go[0] = run && !wq_empty[0];
      wr_go[1] = run && !wq_empty[1] &&
                 !(!wq_empty[0] && (wq_head[0].adr == wq_head[1].adr));
      tag_pop  = rd_vld && !tag_empty;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read   <= 1'b0;
         rd_adr <= '0;
         write  <= '0;
         wr_adr <= '0;
         din    <= '0;
      end else begin
         read  <= rd_go;
         write <= wr_go;
         if (rd_go) rd_adr <= rq_head.adr;
         for (int unsigned i = 0; i < NUMWRPT; i++) begin
            if (wr_go[i]) begin
               wr_adr[i*BITADDR +: BITADDR] <= wq_head[i].adr;
               din[i*WIDTH +: WIDTH]        <= wq_head[i].din;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs_vld    <= 1'b0;
         rs_tag    <= '0;
         rs_dout   <= '0;
         rs_err    <= '0;
         err_unexp <= 1'b0;
      end else begin
         rs_vld    <= tag_pop;
         err_unexp <= rd_vld && tag_empty;
         if (tag_pop) begin
            rs_tag  <= tag_head;
            rs_dout <= rd_dout;
            rs_err  <= {rd_derr, rd_serr};
         end
      end
   end

endmodule

// File: tb/tb_ingress_1r2wg_req_q.sv
// Bench for ingress_1r2wg_req_q: queue-level reference model, a one-cycle
// core responder, directed scenarios and a randomized traffic phase.
module tb_ingress_1r2wg_req_q;

   localparam int W = 32;
   localparam int A = 13;
   localparam int T = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           rq_vld = 1'b0;
   logic           rq_rdy;
   logic [A-1:0]   rq_adr = '0;
   logic [T-1:0]   rq_tag = '0;
   logic [1:0]     wq_vld = '0;
   logic [1:0]     wq_rdy;
   logic [2*A-1:0] wq_adr = '0;
   logic [2*W-1:0] wq_din = '0;
   logic           read;
   logic [A-1:0]   rd_adr;
   logic [1:0]     write;
   logic [2*A-1:0] wr_adr;
   logic [2*W-1:0] din;
   logic           ready = 1'b0;
   logic           rd_vld = 1'b0;
   logic [W-1:0]   rd_dout = '0;
   logic           rd_serr = 1'b0;
   logic           rd_derr = 1'b0;
   logic           rs_vld;
   logic [T-1:0]   rs_tag;
   logic [W-1:0]   rs_dout;
   logic [1:0]     rs_err;
   logic           err_unexp;

   always #5 clk = ~clk;

   ingress_1r2wg_req_q dut (
      .clk(clk), .rst(rst),
      .rq_vld(rq_vld), .rq_rdy(rq_rdy), .rq_adr(rq_adr), .rq_tag(rq_tag),
      .wq_vld(wq_vld), .wq_rdy(wq_rdy), .wq_adr(wq_adr), .wq_din(wq_din),
      .read(read), .rd_adr(rd_adr), .write(write), .wr_adr(wr_adr), .din(din),
      .ready(ready), .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_serr(rd_serr), .rd_derr(rd_derr),
      .rs_vld(rs_vld), .rs_tag(rs_tag), .rs_dout(rs_dout), .rs_err(rs_err),
      .err_unexp(err_unexp)
   );

   typedef struct {logic [A-1:0] adr; logic [T-1:0] tag;} rd_t;
   typedef struct {logic [A-1:0] adr; logic [W-1:0] dat;} wr_t;

   rd_t          exp_rd[$];
   wr_t          exp_w0[$];
   wr_t          exp_w1[$];
   logic [T-1:0] out_tags[$];
   logic [W-1:0] cmem [0:(1<<A)-1];
   bit           running = 0;
   bit           live = 0;
   bit           auto_core = 1;
   bit           rand_err = 0;
   bit           spur_en = 0;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      exp_rd.delete();
      exp_w0.delete();
      exp_w1.delete();
      out_tags.delete();
      running = 0;
      live    = 0;
   endtask

   // One clock: predict this edge from the model, check after it, advance model and core.
   task automatic tick();
      bit           rst_hi, go, e_rd, e_w0, e_w1, acc_r, acc_w0, acc_w1, had_vld, exp_rs;
      logic [T-1:0] e_tag;
      logic [W-1:0] e_dout, rdata;
      logic [1:0]   e_err;
      rd_t          nr;
      wr_t          nw0, nw1;
      rst_hi = rst;
      chk("rq_rdy", rq_rdy, live && exp_rd.size() < 4);
      chk("wq_rdy", wq_rdy, {live && exp_w1.size() < 4, live && exp_w0.size() < 4});
      go   = rst_hi && running && ready;
      e_rd = go && exp_rd.size() > 0 && out_tags.size() < 8;
      e_w0 = go && exp_w0.size() > 0;
      e_w1 = go && exp_w1.size() > 0 &&
             !(exp_w0.size() > 0 && exp_w0[0].adr == exp_w1[0].adr);
      acc_r  = rst_hi && rq_vld && live && exp_rd.size() < 4;
      acc_w0 = rst_hi && wq_vld[0] && live && exp_w0.size() < 4;
      acc_w1 = rst_hi && wq_vld[1] && live && exp_w1.size() < 4;
      nr  = '{adr: rq_adr, tag: rq_tag};
      nw0 = '{adr: wq_adr[A-1:0], dat: wq_din[W-1:0]};
      nw1 = '{adr: wq_adr[2*A-1:A], dat: wq_din[2*W-1:W]};
      had_vld = rst_hi && rd_vld;
      exp_rs  = 0;
      e_tag = '0; e_dout = '0; e_err = '0;
      if (had_vld && out_tags.size() > 0) begin
         exp_rs = 1;
         e_tag  = out_tags.pop_front();
         e_dout = rd_dout;
         e_err  = {rd_derr, rd_serr};
      end
      @(posedge clk);
      #1;
      chk("read", read, e_rd);
      if (e_rd) begin
         chk("rd_adr", rd_adr, exp_rd[0].adr);
         out_tags.push_back(exp_rd[0].tag);
         void'(exp_rd.pop_front());
      end
      chk("write", write, {e_w1, e_w0});
      if (e_w0) begin
         chk("wr_adr0", wr_adr[A-1:0], exp_w0[0].adr);
         chk("din0", din[W-1:0], exp_w0[0].dat);
         void'(exp_w0.pop_front());
      end
      if (e_w1) begin
         chk("wr_adr1", wr_adr[2*A-1:A], exp_w1[0].adr);
         chk("din1", din[2*W-1:W], exp_w1[0].dat);
         void'(exp_w1.pop_front());
      end
      chk("rs_vld", rs_vld, had_vld && exp_rs);
      chk("err_unexp", err_unexp, had_vld && !exp_rs);
      if (exp_rs) begin
         chk("rs_tag", rs_tag, e_tag);
         chk("rs_dout", rs_dout, e_dout);
         chk("rs_err", rs_err, e_err);
      end
      if (acc_r)  exp_rd.push_back(nr);
      if (acc_w0) exp_w0.push_back(nw0);
      if (acc_w1) exp_w1.push_back(nw1);
      if (rst_hi) begin
         live    = 1;
         running = ready;
      end
      // Core responder: read-before-write within a cycle, data one cycle after read.
      rdata = read ? cmem[rd_adr] : '0;
      if (write[0]) cmem[wr_adr[A-1:0]]   = din[W-1:0];
      if (write[1]) cmem[wr_adr[2*A-1:A]] = din[2*W-1:W];
      if (auto_core) begin
         rd_vld  = read || (spur_en && !read && out_tags.size() == 0 && $urandom_range(0, 7) == 0);
         rd_dout = read ? rdata : $urandom;
         rd_serr = rand_err ? 1'($urandom_range(0, 1)) : 1'b0;
         rd_derr = rand_err ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
         rd_vld  = 1'b0;
         rd_serr = 1'b0;
         rd_derr = 1'b0;
      end
   endtask

   task automatic push_rd(input logic [A-1:0] adr, input logic [T-1:0] tag);
      rq_vld = 1'b1;
      rq_adr = adr;
      rq_tag = tag;
      tick();
      rq_vld = 1'b0;
   endtask

   initial begin
      int hold_cnt;
      for (int i = 0; i < (1 << A); i++) cmem[i] = '0;

      // Reset state
      rst = 1'b0;
      tick();
      tick();
      chk("rst_read", read, 0);
      chk("rst_write", write, 0);
      chk("rst_rd_adr", rd_adr, 0);
      chk("rst_wr_adr", wr_adr, 0);
      chk("rst_din", din, 0);
      chk("rst_rs", {rs_vld, rs_tag, rs_err, err_unexp}, 0);
      chk("rst_rs_dout", rs_dout, 0);

      // 1: fill read queue during INIT, then drain when ready rises
      rst   = 1'b1;
      ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) push_rd(13'(20 + i), 4'(i + 8));
      chk("rq_full_rdy", rq_rdy, 0);
      ready = 1'b1;
      for (int i = 0; i < 7; i++) tick();

      // 2: same-address writes on both ports, then read back
      wq_vld = 2'b11;
      wq_adr = {13'd5, 13'd5};
      wq_din = {32'hBBBB_0002, 32'hAAAA_0001};
      tick();
      wq_vld = 2'b00;
      for (int i = 0; i < 3; i++) tick();
      chk("mem5_final", cmem[5], 32'hBBBB_0002);
      push_rd(13'd5, 4'd2);
      tick();
      tick();
      chk("rd5_vld", rs_vld, 1);
      chk("rd5_dout", rs_dout, 32'hBBBB_0002);
      tick();

      // 3: tagged reads 3, 7, 1 with error passthrough
      rand_err = 1;
      push_rd(13'd10, 4'd3);
      push_rd(13'd11, 4'd7);
      push_rd(13'd12, 4'd1);
      for (int i = 0; i < 5; i++) tick();
      rand_err = 0;

      // 4: unexpected rd_vld
      auto_core = 0;
      rd_vld  = 1'b1;
      rd_dout = 32'h1234_5678;
      tick();
      tick();
      auto_core = 1;

      // 5: ready drop mid-stream while pushing
      for (int i = 0; i < 10; i++) begin
         rq_vld = 1'b1;
         rq_adr = 13'(40 + i);
         rq_tag = 4'(i);
         wq_vld = 2'b11;
         wq_adr = {13'(60 + i), 13'(80 + i)};
         wq_din = {32'(i * 3), 32'(i * 5)};
         ready  = !(i >= 2 && i < 5);
         tick();
      end
      rq_vld = 1'b0;
      wq_vld = 2'b00;
      ready  = 1'b1;
      for (int i = 0; i < 8; i++) tick();

      // 6: reset with reads outstanding
      auto_core = 0;
      push_rd(13'd100, 4'd4);
      push_rd(13'd101, 4'd5);
      push_rd(13'd102, 4'd6);
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("arst_read", read, 0);
      chk("arst_write", write, 0);
      chk("arst_rdy", {rq_rdy, wq_rdy}, 0);
      chk("arst_rs", {rs_vld, err_unexp, rs_tag}, 0);
      chk("arst_adr", {rd_adr, wr_adr}, 0);
      model_reset();
      tick();
      rst = 1'b1;
      tick();
      rd_vld  = 1'b1;
      rd_dout = 32'hDEAD_BEEF;
      tick();
      tick();
      auto_core = 1;

      // Randomized traffic with ready drops and spurious returns
      rand_err = 1;
      spur_en  = 1;
      hold_cnt = 0;
      for (int i = 0; i < 400; i++) begin
         rq_vld = 1'($urandom_range(0, 1));
         rq_adr = 13'($urandom_range(0, 7));
         rq_tag = 4'($urandom);
         wq_vld = 2'($urandom);
         wq_adr = {13'($urandom_range(0, 3)), 13'($urandom_range(0, 3))};
         wq_din = {$urandom, $urandom};
         if (hold_cnt > 0) begin
            ready = 1'b0;
            hold_cnt--;
         end else if ($urandom_range(0, 15) == 0) begin
            ready    = 1'b0;
            hold_cnt = 2;
         end else begin
            ready = 1'b1;
         end
         tick();
      end
      rq_vld  = 1'b0;
      wq_vld  = 2'b00;
      ready   = 1'b1;
      spur_en = 0;
      for (int i = 0; i < 12; i++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
